// File: rtl/ser_pkg.sv
// Shared frame constants, FSM state type and the CRC-10 step function for
// the single-wire serial link transmitter.
package ser_pkg;

    // Frame geometry
    localparam int FRAME_BITS = 36;
    localparam int DATA_W     = 24;
    localparam int CRC_W      = 10;

    // Bit index landmarks inside a frame
    localparam logic [5:0] IDX_START   = 6'd0;
    localparam logic [5:0] IDX_DATA_LO = 6'd1;
    localparam logic [5:0] IDX_DATA_HI = 6'd24;
    localparam logic [5:0] IDX_CRC_LO  = 6'd25;
    localparam logic [5:0] IDX_CRC_HI  = 6'd34;
    localparam logic [5:0] IDX_STOP    = 6'd35;

    // x^10+x^9+x^5+x^4+x+1, implicit x^10 term dropped
    localparam logic [9:0] CRC_POLY_DEF = 10'h233;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } ser_state_e;

    // One step of the non-reflected CRC-10 LFSR, one data bit in.
    function automatic logic [9:0] crc10_step(input logic [9:0] crc,
                                              input logic       bit_in,
                                              input logic [9:0] poly);
        logic fb;
        fb = crc[9] ^ bit_in;
        return {crc[8:0], 1'b0} ^ (fb ? poly : 10'd0);
    endfunction

endpackage

// File: rtl/ser_crc_10.sv
// Bit-serial CRC-10 accumulator: clears while clr is high, absorbs one bit
// per valid cycle, holds its value otherwise.
module crc_10
    import ser_pkg::*;
#(
    parameter logic [9:0] POLY = CRC_POLY_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       valid,
    input  logic       indata,
    input  logic       clr,
    output logic [9:0] crc_sum
);

    logic [9:0] crc_r;

    // CRC register: clear has priority over accumulation
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc_r <= 10'd0;
        end else if (clr) begin
            crc_r <= 10'd0;
        end else if (valid) begin
            crc_r <= crc10_step(crc_r, indata, POLY);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc_sum = crc_r;

endmodule

// File: rtl/ser.sv
// Serial frame transmitter: start(0), 24 data bits MSB first, CRC-10 MSB
// first, stop(0), then an idle-high gap. Each bit lasts BIT_DIV clocks.
module ser
    import ser_pkg::*;
#(
    parameter int unsigned BIT_DIV  = 8,
    parameter int unsigned GAP_BITS = 2,
    parameter logic [9:0]  CRC_POLY = CRC_POLY_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [23:0] send_data,
    input  logic        send_req,
    output logic        send_rdy,
    output logic        send_done,
    output logic        tx_busy,
    output logic        tx_data
);

    localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);
    localparam logic [7:0] DIV_PRE  = 8'(BIT_DIV - 2);
    localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);

    ser_state_e  state_r, state_n;
    logic [7:0]  div_r;
    logic [5:0]  idx_r;
    logic [3:0]  gap_r;
    logic [23:0] shift_r;
    logic        tx_r;
    logic        rdy_r;
    logic        busy_r;
    logic        done_r;

    logic        accept_s;
    logic        strobe_s;
    logic        in_data_s;
    logic        crc_valid_s;
    logic        crc_clr_s;
    logic [9:0]  crc_sum_s;
    logic [3:0]  crc_pos_s;
    logic        bit_s;

    assign accept_s    = send_req && (state_r == ST_IDLE);
    assign strobe_s    = (state_r != ST_IDLE) && (div_r == DIV_LAST);
    assign in_data_s   = (idx_r >= IDX_DATA_LO) && (idx_r <= IDX_DATA_HI);
    assign crc_valid_s = strobe_s && (state_r == ST_SEND) && in_data_s;
    assign crc_clr_s   = (state_r == ST_IDLE);
    assign crc_pos_s   = 4'(IDX_CRC_HI - idx_r);

    crc_10 #(
        .POLY(CRC_POLY)
    ) u_crc (
        .clk    (clk),
        .rstn   (rstn),
        .valid  (crc_valid_s),
        .indata (shift_r[23]),
        .clr    (crc_clr_s),
        .crc_sum(crc_sum_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state: frame runs to the stop bit, then the gap, then idle
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_n = ST_SEND;
                else          state_n = ST_IDLE;
            end
            ST_SEND: begin
                if (strobe_s && (idx_r == IDX_STOP)) state_n = ST_GAP;
                else                                 state_n = ST_SEND;
            end
            ST_GAP: begin
                if (strobe_s && (gap_r == GAP_LAST)) state_n = ST_IDLE;
                else                                 state_n = ST_GAP;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Bit-time divider: free-runs 0..BIT_DIV-1 while a frame or gap is active
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_r <= 8'd0;
        end else if (accept_s || (state_r == ST_IDLE) || strobe_s) begin
            div_r <= 8'd0;
        end else begin
            div_r <= div_r + 8'd1;
        end
    end

    // Bit index and gap counter, both advance on the bit strobe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_r <= 6'd0;
            gap_r <= 4'd0;
        end else if (accept_s) begin
            idx_r <= 6'd0;
            gap_r <= 4'd0;
        end else if (strobe_s && (state_r == ST_SEND)) begin
            idx_r <= (idx_r == IDX_STOP) ? 6'd0 : idx_r + 6'd1;
            gap_r <= 4'd0;
        end else if (strobe_s && (state_r == ST_GAP)) begin
            idx_r <= idx_r;
            gap_r <= (gap_r == GAP_LAST) ? 4'd0 : gap_r + 4'd1;
        end else begin
            idx_r <= idx_r;
            gap_r <= gap_r;
        end
    end

    // Data shift register: loaded on accept, shifted after each data bit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_r <= 24'd0;
        end else if (accept_s) begin
            shift_r <= send_data;
        end else if (crc_valid_s) begin
            shift_r <= {shift_r[22:0], 1'b0};
        end else begin
            shift_r <= shift_r;
        end
    end

    // Line bit selection from the current state and bit index
    always_comb begin
        bit_s = 1'b1;
        case (state_r)
            ST_SEND: begin
                if (idx_r == IDX_START) begin
                    bit_s = 1'b0;
                end else if (in_data_s) begin
                    bit_s = shift_r[23];
                end else if ((idx_r >= IDX_CRC_LO) && (idx_r <= IDX_CRC_HI)) begin
                    bit_s = crc_sum_s[crc_pos_s];
                end else begin
                    bit_s = 1'b0;
                end
            end
            ST_IDLE: bit_s = 1'b1;
            ST_GAP:  bit_s = 1'b1;
            default: bit_s = 1'b1;
        endcase
    end

    // Registered outputs; send_done is predicted one cycle early so that it
    // lands on the final gap cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_r   <= 1'b1;
            rdy_r  <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            tx_r   <= bit_s;
            rdy_r  <= (state_n == ST_IDLE);
            busy_r <= (state_n != ST_IDLE);
            done_r <= (state_r == ST_GAP) && (gap_r == GAP_LAST) && (div_r == DIV_PRE);
        end
    end

    assign tx_data   = tx_r;
    assign send_rdy  = rdy_r;
    assign send_done = done_r;
    // Busy covers the accept cycle itself, before the state has moved
    assign tx_busy   = busy_r || accept_s;

endmodule

// File: tb/tb_ser.sv
// Self-checking bench for ser: line waveform vs. a polynomial-division
// reference frame, a mid-bit sampling receiver model, back-to-back timing,
// ignored requests, and mid-frame reset.
module tb_ser;

    localparam int DA = 4;
    localparam int GA = 2;
    localparam int DB = 2;
    localparam int GB = 1;

    logic        clk;
    logic        rstn;
    logic [23:0] data_a, data_b;
    logic        req_a, req_b;
    logic        rdy_a, rdy_b, done_a, done_b, busy_a, busy_b, tx_a, tx_b;

    int tests;
    int fails;

    ser #(.BIT_DIV(DA), .GAP_BITS(GA)) dut_a (
        .clk(clk), .rstn(rstn), .send_data(data_a), .send_req(req_a),
        .send_rdy(rdy_a), .send_done(done_a), .tx_busy(busy_a), .tx_data(tx_a)
    );

    ser #(.BIT_DIV(DB), .GAP_BITS(GB)) dut_b (
        .clk(clk), .rstn(rstn), .send_data(data_b), .send_req(req_b),
        .send_rdy(rdy_b), .send_done(done_b), .tx_busy(busy_b), .tx_data(tx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Remainder of v(x) modulo the full 11-bit generator x^10+x^9+x^5+x^4+x+1
    function automatic logic [9:0] residue(input logic [33:0] v);
        logic [33:0] r;
        r = v;
        for (int i = 33; i >= 10; i--) begin
            if (r[i]) r[i -: 11] = r[i -: 11] ^ 11'h633;
        end
        return r[9:0];
    endfunction

    function automatic logic [35:0] ref_frame(input logic [23:0] d);
        return {1'b0, d, residue({d, 10'd0}), 1'b0};
    endfunction

    // One frame on dut_a: per-cycle checks, then mid-bit decode of the line.
    task automatic run_a(input logic [23:0] d, input int glitch_at, input logic [23:0] gdata,
                         input bit corrupt, input int corrupt_bit,
                         output logic [23:0] rx_word, output bit rx_ok);
        logic [35:0] fr;
        logic        rx_line[$];
        logic [35:0] rx_bits;
        logic        expv;
        int          last, bad_tx, bad_ctl, f;
        fr      = ref_frame(d);
        last    = (36 + GA) * DA + 1;
        bad_tx  = 0;
        bad_ctl = 0;
        @(negedge clk);
        check("rdy_before_accept", 32'(rdy_a), 32'd1);
        req_a  = 1'b1;
        data_a = d;
        #1;
        check("busy_accept_cycle", 32'(busy_a), 32'd1);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            req_a  = 1'b0;
            data_a = 24'($urandom());
            if (c == glitch_at) begin
                req_a  = 1'b1;
                data_a = gdata;
            end
            #1;
            if (c >= 2 && c <= 36 * DA + 1) expv = fr[35 - (c - 2) / DA];
            else                            expv = 1'b1;
            if (tx_a !== expv) bad_tx++;
            if (busy_a !== (c < last))              bad_ctl++;
            if (rdy_a  !== (c == last))             bad_ctl++;
            if (done_a !== (c == (36 + GA) * DA))   bad_ctl++;
            rx_line.push_back(tx_a);
        end
        req_a = 1'b0;
        check("frame_line_bits", 32'(bad_tx), 32'd0);
        check("frame_ctl_timing", 32'(bad_ctl), 32'd0);
        f = -1;
        for (int i = 0; i < rx_line.size(); i++) begin
            if (f < 0 && rx_line[i] == 1'b0) f = i;
        end
        if (f < 0) f = 0;
        if (corrupt) begin
            for (int k = 0; k < DA; k++) rx_line[f + corrupt_bit * DA + k] = ~rx_line[f + corrupt_bit * DA + k];
        end
        for (int j = 0; j < 36; j++) begin
            if (f + j * DA + DA / 2 < rx_line.size()) rx_bits[35 - j] = rx_line[f + j * DA + DA / 2];
            else                                     rx_bits[35 - j] = 1'b1;
        end
        rx_word = rx_bits[34:11];
        rx_ok   = (rx_bits[35] == 1'b0) && (rx_bits[0] == 1'b0) && (residue(rx_bits[34:1]) == 10'd0);
    endtask

    initial begin
        logic [23:0] w, rxw;
        bit          ok;
        int          idle_bad, cyc, done_cnt, rdy_hi;
        int          acc[$];
        logic [23:0] dir [3];

        tests  = 0;
        fails  = 0;
        rstn   = 1'b0;
        req_a  = 1'b0;
        req_b  = 1'b0;
        data_a = 24'd0;
        data_b = 24'd0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("reset_tx", 32'(tx_a), 32'd1);
        check("reset_rdy", 32'(rdy_a), 32'd1);
        check("reset_done", 32'(done_a), 32'd0);
        check("reset_busy", 32'(busy_a), 32'd0);
        check("reset_tx_b", 32'(tx_b), 32'd1);

        // Directed A5A5A5 frame
        run_a(24'hA5A5A5, 0, 24'd0, 1'b0, 0, rxw, ok);
        check("a5_rx_ok", 32'(ok), 32'd1);
        check("a5_rx_word", 32'(rxw), 32'hA5A5A5);

        // Corner words then random words through the receiver model
        dir[0] = 24'h000000;
        dir[1] = 24'hFFFFFF;
        dir[2] = 24'h800001;
        for (int i = 0; i < 3; i++) begin
            run_a(dir[i], 0, 24'd0, 1'b0, 0, rxw, ok);
            check("corner_rx_ok", 32'(ok), 32'd1);
            check("corner_rx_word", 32'(rxw), 32'(dir[i]));
        end
        for (int i = 0; i < 200; i++) begin
            w = 24'($urandom());
            run_a(w, 0, 24'd0, 1'b0, 0, rxw, ok);
            check("rand_rx_ok", 32'(ok), 32'd1);
            check("rand_rx_word", 32'(rxw), 32'(w));
        end

        // Request during a frame with other data: ignored, no extra frame
        run_a(24'h3C3C3C, 60, 24'hC3C3C3, 1'b0, 0, rxw, ok);
        check("glitch_rx_word", 32'(rxw), 32'h3C3C3C);
        idle_bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || rdy_a !== 1'b1) idle_bad++;
        end
        check("no_extra_frame", 32'(idle_bad), 32'd0);

        // CRC-bit error on the loopback copy rejected; next clean frame received
        run_a(24'h5A0F33, 0, 24'd0, 1'b1, 30, rxw, ok);
        check("crc_err_rejected", 32'(ok), 32'd0);
        run_a(24'h0BEEF1, 0, 24'd0, 1'b0, 0, rxw, ok);
        check("after_err_ok", 32'(ok), 32'd1);
        check("after_err_word", 32'(rxw), 32'h0BEEF1);

        // Reset in the middle of bit index 12
        @(negedge clk);
        req_a  = 1'b1;
        data_a = 24'hFEDCBA;
        @(negedge clk);
        req_a  = 1'b0;
        for (int c = 2; c <= 12 * DA + 2; c++) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("rst_tx_async", 32'(tx_a), 32'd1);
        check("rst_done", 32'(done_a), 32'd0);
        idle_bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_a !== 1'b0 || tx_a !== 1'b1) idle_bad++;
        end
        rstn = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done_a !== 1'b0 || tx_a !== 1'b1) idle_bad++;
        end
        check("rst_quiet", 32'(idle_bad), 32'd0);
        check("rst_rdy", 32'(rdy_a), 32'd1);
        run_a(24'h123456, 0, 24'd0, 1'b0, 0, rxw, ok);
        check("post_rst_ok", 32'(ok), 32'd1);
        check("post_rst_word", 32'(rxw), 32'h123456);

        // Back-to-back on dut_b with send_req held high
        @(negedge clk);
        req_b    = 1'b1;
        cyc      = 0;
        done_cnt = 0;
        rdy_hi   = 0;
        while ((acc.size() < 3 || done_cnt < 3) && cyc < 600) begin
            data_b = 24'($urandom());
            #1;
            if (rdy_b && req_b) acc.push_back(cyc);
            if (rdy_b) rdy_hi++;
            if (done_b) done_cnt++;
            @(negedge clk);
            cyc++;
            if (acc.size() == 3) req_b = 1'b0;
        end
        check("b2b_timeout", 32'(cyc < 600), 32'd1);
        check("b2b_accepts", 32'(acc.size()), 32'd3);
        if (acc.size() == 3) begin
            check("b2b_space_1", 32'(acc[1] - acc[0]), 32'((36 + GB) * DB + 1));
            check("b2b_space_2", 32'(acc[2] - acc[1]), 32'((36 + GB) * DB + 1));
        end
        check("b2b_done_count", 32'(done_cnt), 32'd3);
        check("b2b_rdy_cycles", 32'(rdy_hi), 32'd3);
        #1;
        check("b2b_idle_rdy", 32'(rdy_b), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
